// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - request/response bundle between the EX stage and the multiply/divide unit
// Signals:
//   start        requester -> unit  one-cycle qualifier for op/src_a/src_b
//   op[2:0]      requester -> unit  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
//   src_a[31:0]  requester -> unit  rs operand (dividend / multiplicand / mthi-mtlo data)
//   src_b[31:0]  requester -> unit  rt operand (divisor / multiplier)
//   busy         unit -> requester  multi-cycle operation in progress
//   hi[31:0]     unit -> requester  HI register
//   lo[31:0]     unit -> requester  LO register
interface md_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, src_a, src_b, input busy, hi, lo);
  modport slave  (input start, op, src_a, src_b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - fixed-latency multiply/divide unit holding HI/LO for the MIPS pipeline
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   md     md_unit_if.slave: start/op/src_a/src_b in, busy/hi/lo out
// The result is computed from the operands sampled on the accept edge and parked
// in res_q; hi/lo only change when the busy countdown expires.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  md
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      res_q, res_d;
  logic             wr_q, wr_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic signed [63:0] smul_a, smul_b, smul_p;
  logic [63:0]        umul_p;
  logic signed [32:0] sdiv_a, sdiv_b, sdiv_q, sdiv_r;
  logic [31:0]        udiv_b, udiv_q, udiv_r;
  logic               div_zero;
  logic               div_unused;

  // Signed divide is done in 33 bits so 0x80000000 / -1 yields +2^31, whose low
  // word is the architecturally expected 0x80000000. A zero divisor is replaced
  // by 1 only to keep the arithmetic defined; that result is never written.
  always_comb begin
    div_zero = (md.src_b == 32'd0);
    smul_a   = {{32{md.src_a[31]}}, md.src_a};
    smul_b   = {{32{md.src_b[31]}}, md.src_b};
    smul_p   = smul_a * smul_b;
    umul_p   = {32'd0, md.src_a} * {32'd0, md.src_b};
    sdiv_a   = {md.src_a[31], md.src_a};
    sdiv_b   = div_zero ? 33'sd1 : {md.src_b[31], md.src_b};
    sdiv_q   = sdiv_a / sdiv_b;
    sdiv_r   = sdiv_a % sdiv_b;
    udiv_b   = div_zero ? 32'd1 : md.src_b;
    udiv_q   = md.src_a / udiv_b;
    udiv_r   = md.src_a % udiv_b;
  end

  assign div_unused = sdiv_q[32] ^ sdiv_r[32];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (md.start) begin
          case (md.op)
            OP_MULT: begin
              res_d   = smul_p;
              wr_d    = 1'b1;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_MULTU: begin
              res_d   = umul_p;
              wr_d    = 1'b1;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_DIV: begin
              res_d   = {sdiv_r[31:0], sdiv_q[31:0]};
              wr_d    = !div_zero;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_DIVU: begin
              res_d   = {udiv_r, udiv_q};
              wr_d    = !div_zero;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = md.src_a;
            OP_MTLO: lo_d = md.src_a;
            default: ;
          endcase
        end
      end
      default: begin
        // start is deliberately not looked at here: requests during RUN,
        // including on the completion edge, are dropped.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (wr_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.busy = (state_q == RUN);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit
// Ports: none (top-level bench); drives md_unit through an md_unit_if instance.
module tb_md_unit;

  logic clk;
  logic reset;
  md_unit_if md_if ();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // inject: 0 none, 1 multu request on the 2nd busy cycle, 2 mthi request on the completion edge
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int n_cyc, input logic [63:0] exp,
                       input int inject);
    int busy_cnt;
    logic [63:0] res;
    @(negedge clk);
    md_if.start = 1'b1;
    md_if.op    = op;
    md_if.src_a = a;
    md_if.src_b = b;
    sb_q.push_back(exp);
    @(negedge clk);
    md_if.start = 1'b0;
    md_if.op    = 3'd6;
    md_if.src_a = 32'd0;
    md_if.src_b = 32'd0;
    check_eq({tag, "_hold"}, {md_if.hi, md_if.lo}, {mhi, mlo});
    busy_cnt = 0;
    while (md_if.busy === 1'b1 && busy_cnt < 64) begin
      busy_cnt++;
      if (inject == 1 && busy_cnt == 2) begin
        md_if.start = 1'b1;
        md_if.op    = 3'd1;
        md_if.src_a = 32'h0001_2345;
        md_if.src_b = 32'h0006_789A;
      end else if (inject == 2 && busy_cnt == n_cyc) begin
        md_if.start = 1'b1;
        md_if.op    = 3'd4;
        md_if.src_a = 32'hBAD0_BAD0;
      end else begin
        md_if.start = 1'b0;
        md_if.op    = 3'd6;
      end
      @(negedge clk);
    end
    md_if.start = 1'b0;
    md_if.op    = 3'd6;
    check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(n_cyc));
    check_eq({tag, "_sb_size"}, 64'(sb_q.size()), 64'd1);
    if (sb_q.size() != 0) begin
      res = sb_q.pop_front();
      check_eq({tag, "_hilo"}, {md_if.hi, md_if.lo}, res);
      mhi = res[63:32];
      mlo = res[31:0];
    end
  endtask

  task automatic do_mt(input string tag, input logic [2:0] op, input logic [31:0] v);
    @(negedge clk);
    md_if.start = 1'b1;
    md_if.op    = op;
    md_if.src_a = v;
    @(negedge clk);
    md_if.start = 1'b0;
    md_if.op    = 3'd6;
    if (op == 3'd4) mhi = v; else mlo = v;
    check_eq({tag, "_hilo"}, {md_if.hi, md_if.lo}, {mhi, mlo});
    check_eq({tag, "_busy"}, 64'(md_if.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    int busy_seen;
    reset       = 1'b0;
    md_if.start = 1'b0;
    md_if.op    = 3'd6;
    md_if.src_a = 32'd0;
    md_if.src_b = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("reset_hilo", {md_if.hi, md_if.lo}, 64'd0);
    check_eq("reset_busy", 64'(md_if.busy), 64'd0);
    reset = 1'b1;

    // mthi then mtlo on consecutive edges
    @(negedge clk);
    md_if.start = 1'b1; md_if.op = 3'd4; md_if.src_a = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("mthi_hilo", {md_if.hi, md_if.lo}, {32'hDEAD_BEEF, 32'd0});
    check_eq("mthi_busy", 64'(md_if.busy), 64'd0);
    md_if.op = 3'd5; md_if.src_a = 32'h1234_5678;
    @(negedge clk);
    md_if.start = 1'b0; md_if.op = 3'd6;
    mhi = 32'hDEAD_BEEF; mlo = 32'h1234_5678;
    check_eq("mtlo_hilo", {md_if.hi, md_if.lo}, {mhi, mlo});
    check_eq("mtlo_busy", 64'(md_if.busy), 64'd0);

    do_op("mult_neg",   3'd0, 32'hFFFF_FFFE, 32'd3, 5, 64'hFFFF_FFFF_FFFF_FFFA, 1);
    do_op("multu_big",  3'd1, 32'hFFFF_FFFE, 32'd3, 5, 64'h0000_0002_FFFF_FFFA, 2);
    do_op("div_neg",    3'd2, 32'hFFFF_FFF9, 32'd2, 10, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    do_op("divu_7_2",   3'd3, 32'd7, 32'd2, 10, 64'h0000_0001_0000_0003, 0);
    do_op("div_ovf",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 64'h0000_0000_8000_0000, 0);

    do_mt("mthi_11", 3'd4, 32'h11);
    do_mt("mtlo_22", 3'd5, 32'h22);
    do_op("divu_zero",  3'd3, 32'd99, 32'd0, 10, 64'h0000_0011_0000_0022, 0);
    do_op("div_zero",   3'd2, 32'hFFFF_FF00, 32'd0, 10, 64'h0000_0011_0000_0022, 0);

    // op 6/7 are no-ops
    @(negedge clk);
    md_if.start = 1'b1; md_if.op = 3'd6; md_if.src_a = 32'hCAFE_0001;
    @(negedge clk);
    md_if.op = 3'd7;
    check_eq("nop6_busy", 64'(md_if.busy), 64'd0);
    @(negedge clk);
    md_if.start = 1'b0; md_if.op = 3'd6;
    check_eq("nop7_busy", 64'(md_if.busy), 64'd0);
    check_eq("nop_hilo", {md_if.hi, md_if.lo}, {mhi, mlo});

    do_op("mult_6x7",   3'd0, 32'd6, 32'd7, 5, 64'd42, 0);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      do_op("multu_rnd", 3'd1, ra, rb, 5, {32'd0, ra} * {32'd0, rb}, 0);
      rb = $urandom_range(1, 5000);
      do_op("divu_rnd", 3'd3, ra, rb, 10, {ra % rb, ra / rb}, 0);
    end

    // reset three cycles into a divide aborts it and clears HI/LO immediately
    @(negedge clk);
    md_if.start = 1'b1; md_if.op = 3'd3; md_if.src_a = 32'd1000; md_if.src_b = 32'd3;
    @(negedge clk);
    md_if.start = 1'b0; md_if.op = 3'd6;
    busy_seen = 0;
    repeat (3) begin
      if (md_if.busy === 1'b1) busy_seen++;
      @(negedge clk);
    end
    check_eq("abort_busy_before", 64'(busy_seen), 64'd3);
    #2 reset = 1'b0;
    #1;
    check_eq("abort_hilo", {md_if.hi, md_if.lo}, 64'd0);
    check_eq("abort_busy", 64'(md_if.busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    mhi = 32'd0; mlo = 32'd0;
    repeat (12) @(negedge clk);
    check_eq("abort_no_write", {md_if.hi, md_if.lo}, 64'd0);
    do_op("mult_after_rst", 3'd0, 32'd6, 32'd7, 5, 64'd42, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit for the five-stage MIPS pipeline.
- Sits beside the EX stage: it consumes register operands from EX and produces the HI/LO values read back by mfhi/mflo.
- It models fixed multi-cycle latency with a busy flag. The hazard unit uses that flag to stall any later mult/div/mthi/mtlo/mfhi/mflo in ID.

Parameters:
MULT_CYCLES, 5, cycles busy stays high for mult/multu (>=1)
DIV_CYCLES, 10, cycles busy stays high for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  one-cycle qualifier; op/src_a/src_b are valid this cycle
op  input  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo 6,7=no-op
src_a  input  32  rs operand (dividend / multiplicand / mthi-mtlo data)
src_b  input  32  rt operand (divisor / multiplier)
busy  output  1  operation in progress
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, cycle counter=0, pending result=0. Takes effect immediately and aborts any operation in flight; no result is written.
- States: IDLE, RUN.
- IDLE, start=1, op in {0,1,2,3}, sampled at edge T0:
  - Compute the 64-bit result from src_a/src_b as sampled at T0 and hold it internally. Later input changes have no effect.
  - Load counter with MULT_CYCLES (ops 0,1) or DIV_CYCLES (ops 2,3); go to RUN.
  - busy=1 from just after T0.
- RUN: counter decrements each edge. At edge T0+N (N = loaded count), write hi/lo from the held result, set busy=0, return to IDLE. busy is high for exactly N cycles.
- hi/lo remain unchanged during RUN; the old values stay visible until completion.
- mthi/mtlo (start=1, op 4/5, IDLE): hi (or lo) <= src_a at that edge. busy stays 0; the other register is unchanged.
- start=1 during RUN, any op: ignored, with no effect on the counter, hi, lo or held result. The hazard unit must prevent this case; the behaviour is defined here for robustness.
- start=1 with op 6/7: no effect.
- start=1 at the completion edge (busy still 1 in that cycle): ignored. A new op is accepted only when busy=0.
- mult: signed 32x32->64, hi=upper, lo=lower. multu: unsigned.
- div: signed, lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned, lo=quotient, hi=remainder.
- Divide by zero (div or divu, src_b=0): the full busy period still elapses, then hi/lo keep their previous values (no write).
- busy is a registered output with no combinational path from start. The hazard unit ORs start-of-op in ID/EX with busy for stall generation.

Test Plan:
- Reset low mid-div (3 cycles into RUN), then released: hi=0, lo=0, busy=0 immediately. The next mult starts normally, producing 5 busy cycles and a correct result.
- mult src_a=0xFFFFFFFE (-2), src_b=3: busy high for exactly 5 cycles. After completion hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu on the same inputs gives hi=0x00000002, lo=0xFFFFFFFA.
- div src_a=0xFFFFFFF9 (-7), src_b=2: busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 gives lo=3, hi=1.
- Edge cases:
  - div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - divu by 0, with hi=0x11, lo=0x22 beforehand: busy for 10 cycles, then hi/lo still 0x11/0x22.
- mthi 0xDEADBEEF, then next cycle mtlo 0x12345678: hi and lo update one edge each, busy never asserts. A multu issued during RUN of a prior mult is ignored, and hi/lo equal the first result only.
- Operands change on the cycle after start (mult 6*7, then src_a/src_b driven to 0): final lo=42, hi=0.
